// File: rtl/handshake_const_sink_pkg.sv
`default_nettype none
// ============================================================================
// Module      : handshake_const_sink_pkg
// Description : Shared types and defaults for the constant-token sink.
//               It holds the FSM state encoding (1 bit), the default
//               parameter values, and a helper that sizes the batch counter.
// Revision    : 1.0 - initial release
// ============================================================================
package handshake_const_sink_pkg;

  // Receive tokens, or hold a pending batch-complete control token.
  typedef enum logic [0:0] {
    ST_RECV = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  localparam int              DEF_DATA_WIDTH  = 18;
  localparam logic [17:0]     DEF_EXPECTED    = 18'h1AD57;
  localparam int              DEF_TOKEN_COUNT = 4;
  localparam int              DEF_CNT_WIDTH   = 16;

  // The batch counter must reach TOKEN_COUNT. It stays at that value while
  // the control token is pending, so it needs clog2(TOKEN_COUNT+1) bits.
  function automatic int batch_width(input int token_count);
    return (token_count < 1) ? 1 : $clog2(token_count + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/handshake_const_sink_if.sv
`default_nettype none
// ============================================================================
// Module      : handshake_const_sink_if
// Description : Token channel between a constant generator and the sink.
//               ins/ins_valid/ins_ready  - data token handshake
//               done_valid/done_ready    - batch-complete control token
//               master : the upstream/consumer side (testbench or tile)
//               slave  : the sink
// Revision    : 1.0 - initial release
// ============================================================================
interface handshake_const_sink_if
  import handshake_const_sink_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0] ins;
  logic                  ins_valid;
  logic                  ins_ready;
  logic                  done_valid;
  logic                  done_ready;

  modport master (
    output ins,
    output ins_valid,
    input  ins_ready,
    input  done_valid,
    output done_ready
  );

  modport slave (
    input  ins,
    input  ins_valid,
    output ins_ready,
    output done_valid,
    input  done_ready
  );

endinterface
`default_nettype wire

// File: rtl/handshake_const_sink_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : hs_sat_counter
// Description : Up-counter that saturates at all-ones. It has a synchronous
//               clear and an asynchronous active-low reset. When clear and
//               enable are both high, the clear applies first and the
//               enable then counts, so the result is 1.
//   clk  in  clock, rising edge
//   rst  in  asynchronous reset, active-low
//   en   in  count enable
//   clr  in  synchronous clear
//   cnt  out count value [W-1:0]
// Revision    : 1.0 - initial release
// ============================================================================
module hs_sat_counter #(
  parameter int W = 16
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         en,
  input  wire logic         clr,
  output logic [W-1:0]      cnt
);

  localparam logic [W-1:0] C_MAX = {W{1'b1}};
  localparam logic [W-1:0] C_ONE = W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= en ? C_ONE : '0;
    end else if (en && (cnt != C_MAX)) begin
      cnt <= cnt + C_ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/handshake_const_sink.sv
`default_nettype none
// ============================================================================
// Module      : handshake_const_sink
// Description : Receives constant tokens over a valid/ready handshake and
//               checks each one against EXPECTED. Each batch of TOKEN_COUNT
//               tokens returns one control token. The module keeps
//               saturating match/error counts and a sticky first-bad
//               capture.
//   clk        in  clock, rising edge
//   rst        in  asynchronous reset, active-low
//   hs         if  slave side of the token channel
//   clear      in  synchronous pulse: zero statistics and sticky flags
//   match_cnt  out tokens equal to EXPECTED (saturating)
//   err_cnt    out tokens differing from EXPECTED (saturating)
//   mismatch   out sticky: a bad token was seen since reset/clear
//   first_bad  out value of the first bad token since reset/clear
// Revision    : 1.0 - initial release
// ============================================================================
module handshake_const_sink
  import handshake_const_sink_pkg::*;
#(
  parameter int                    DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] EXPECTED    = DEF_EXPECTED,
  parameter int                    TOKEN_COUNT = DEF_TOKEN_COUNT,
  parameter int                    CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  handshake_const_sink_if.slave     hs,
  input  wire logic                 clear,
  output logic [CNT_WIDTH-1:0]      match_cnt,
  output logic [CNT_WIDTH-1:0]      err_cnt,
  output logic                      mismatch,
  output logic [DATA_WIDTH-1:0]     first_bad
);

  localparam int            BW       = batch_width(TOKEN_COUNT);
  localparam logic [BW-1:0] LAST_IDX = BW'(TOKEN_COUNT - 1);
  localparam logic [BW-1:0] BW_ONE   = BW'(1);

  state_t        state;
  logic [BW-1:0] batch_cnt;
  logic          ins_ready_r;
  logic          done_valid_r;

  logic          accept;
  logic          good;

  // ins_ready_r is a registered copy of (state == ST_RECV). Gating the
  // accept with it means that ins is never looked at when it is not being
  // consumed. An X value on ins therefore cannot reach any state.
  assign accept = hs.ins_valid && ins_ready_r;
  assign good   = (hs.ins == EXPECTED);

  assign hs.ins_ready  = ins_ready_r;
  assign hs.done_valid = done_valid_r;

  // -------------------------------------------------------------------------
  // Batch FSM. The handshake outputs are registered alongside the state.
  // done_ready has no combinational path to ins_ready.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_RECV;
      batch_cnt    <= '0;
      ins_ready_r  <= 1'b1;
      done_valid_r <= 1'b0;
    end else begin
      case (state)
        ST_RECV: begin
          if (accept) begin
            batch_cnt <= batch_cnt + BW_ONE;
            if (batch_cnt == LAST_IDX) begin
              state        <= ST_DONE;
              ins_ready_r  <= 1'b0;
              done_valid_r <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (hs.done_ready) begin
            state        <= ST_RECV;
            batch_cnt    <= '0;
            ins_ready_r  <= 1'b1;
            done_valid_r <= 1'b0;
          end
        end
        default: begin
          state        <= ST_RECV;
          batch_cnt    <= '0;
          ins_ready_r  <= 1'b1;
          done_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Statistics counters
  // -------------------------------------------------------------------------
  hs_sat_counter #(.W(CNT_WIDTH)) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .en  (accept && good),
    .clr (clear),
    .cnt (match_cnt)
  );

  hs_sat_counter #(.W(CNT_WIDTH)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .en  (accept && !good),
    .clr (clear),
    .cnt (err_cnt)
  );

  // -------------------------------------------------------------------------
  // Sticky first-bad capture. A clear in the same cycle makes the flag look
  // un-set. A bad token arriving with the clear is therefore captured as
  // the new first bad token.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mismatch  <= 1'b0;
      first_bad <= '0;
    end else if (accept && !good && (clear || !mismatch)) begin
      mismatch  <= 1'b1;
      first_bad <= hs.ins;
    end else if (clear) begin
      mismatch  <= 1'b0;
      first_bad <= '0;
    end
  end

endmodule
`default_nettype wire
